// File: rtl/nano_mem_responder.sv
// NanoCPU word RAM: combinational read, posedge write. A byte-serial loader holds the CPU in reset while it writes.
// The loader is always ready during a load and never stalls the byte stream. CPU writes are taken only in IDLE.
module nano_mem_responder #(
    parameter int AW          = 8,
    parameter int RELEASE_CYC = 2
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [AW-1:0] address,
    input  logic [15:0]   dataW,
    output logic [15:0]   dataR,
    input  logic          ce,
    input  logic          we,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          cpu_rst,
    output logic [AW:0]   load_cnt,
    output logic          overflow
);

    localparam int            HW        = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RELEASE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD_HI = 2'd1,
        S_LOAD_LO = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [15:0]   r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_load_cnt;
    logic          r_overflow;
    logic          r_wrapped;
    logic [7:0]    r_hold;
    logic [HW-1:0] r_hold_cnt;
    logic          r_cpu_rst;

    logic          w_ld_ready;
    logic          w_word_vld;
    logic [15:0]   w_word_dat;
    logic          w_cpu_wr;
    logic          w_load_wr;

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= S_RELEASE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_ready  = 1'b0;
        w_word_vld  = 1'b0;
        w_word_dat  = 16'h0000;
        w_cpu_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cpu_wr = ce & we;
                if (ld_start) begin
                    w_state_nxt = S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                w_ld_ready = 1'b1;
                if (ld_valid) begin
                    if (ld_last) begin
                        // Odd-length program: final word is padded with a zero low byte
                        w_word_vld  = 1'b1;
                        w_word_dat  = {ld_byte, 8'h00};
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_state_nxt = S_LOAD_LO;
                    end
                end
            end
            S_LOAD_LO: begin
                w_ld_ready = 1'b1;
                if (ld_valid) begin
                    w_word_vld  = 1'b1;
                    w_word_dat  = {r_hold, ld_byte};
                    w_state_nxt = ld_last ? S_RELEASE : S_LOAD_HI;
                end
            end
            S_RELEASE: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_RELEASE;
            end
        endcase
    end

    // Once the pointer has wrapped, further words in this load are discarded
    assign w_load_wr = w_word_vld & ~r_wrapped;

    always_ff @(posedge ck) begin
        if (rst) begin
            r_cpu_rst  <= 1'b1;
            r_load_cnt <= '0;
            r_overflow <= 1'b0;
            r_wrapped  <= 1'b0;
            r_ptr      <= '0;
            r_hold     <= 8'h00;
            r_hold_cnt <= HOLD_INIT;
        end else begin
            r_cpu_rst <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE && ld_start) begin
                r_ptr      <= '0;
                r_load_cnt <= '0;
                r_overflow <= 1'b0;
                r_wrapped  <= 1'b0;
            end
            if (r_state == S_LOAD_HI && ld_valid) begin
                r_hold <= ld_byte;
            end
            if (w_word_vld) begin
                if (r_wrapped) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_ptr      <= r_ptr + AW'(1);
                    r_load_cnt <= r_load_cnt + (AW+1)'(1);
                    if (r_ptr == '1) begin
                        r_wrapped <= 1'b1;
                    end
                end
            end
            if (w_state_nxt == S_RELEASE && r_state != S_RELEASE) begin
                r_hold_cnt <= HOLD_INIT;
            end else if (r_state == S_RELEASE && r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HW'(1);
            end
        end
    end

    // RAM is deliberately not cleared by rst
    always_ff @(posedge ck) begin
        if (!rst) begin
            if (w_load_wr) begin
                r_mem[r_ptr] <= w_word_dat;
            end else if (w_cpu_wr) begin
                r_mem[address] <= dataW;
            end
        end
    end

    assign dataR    = r_mem[address];
    assign ld_ready = w_ld_ready;
    assign cpu_rst  = r_cpu_rst;
    assign load_cnt = r_load_cnt;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_nano_mem_responder.sv
// Directed bench for nano_mem_responder: a default-size instance plus an AW=2 instance for the wrap/overflow case.
module tb_nano_mem_responder;

    logic        ck;
    logic        rst;

    logic [7:0]  address;
    logic [15:0] dataW;
    logic [15:0] dataR;
    logic        ce, we;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_byte;
    logic        ld_ready, cpu_rst, overflow;
    logic [8:0]  load_cnt;

    logic [1:0]  a2_address;
    logic [15:0] a2_dataW;
    logic [15:0] a2_dataR;
    logic        a2_ce, a2_we;
    logic        a2_ld_start, a2_ld_valid, a2_ld_last;
    logic [7:0]  a2_ld_byte;
    logic        a2_ld_ready, a2_cpu_rst, a2_overflow;
    logic [2:0]  a2_load_cnt;

    int n_vec = 0;
    int n_err = 0;

    nano_mem_responder #(.AW(8), .RELEASE_CYC(2)) u_dut (
        .ck(ck), .rst(rst), .address(address), .dataW(dataW), .dataR(dataR),
        .ce(ce), .we(we), .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_ready(ld_ready), .cpu_rst(cpu_rst), .load_cnt(load_cnt),
        .overflow(overflow)
    );

    nano_mem_responder #(.AW(2), .RELEASE_CYC(2)) u_dut2 (
        .ck(ck), .rst(rst), .address(a2_address), .dataW(a2_dataW), .dataR(a2_dataR),
        .ce(a2_ce), .we(a2_we), .ld_start(a2_ld_start), .ld_valid(a2_ld_valid), .ld_byte(a2_ld_byte),
        .ld_last(a2_ld_last), .ld_ready(a2_ld_ready), .cpu_rst(a2_cpu_rst), .load_cnt(a2_load_cnt),
        .overflow(a2_overflow)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b, input logic last);
        a2_ld_valid = 1'b1;
        a2_ld_byte  = b;
        a2_ld_last  = last;
        step();
        a2_ld_valid = 1'b0;
        a2_ld_last  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string tag);
        address = a;
        #1;
        chk(tag, 32'(dataR), 32'(exp));
    endtask

    task automatic rd2(input logic [1:0] a, input logic [15:0] exp, input string tag);
        a2_address = a;
        #1;
        chk(tag, 32'(a2_dataR), 32'(exp));
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        address = 8'h00; dataW = 16'h0000; ce = 1'b0; we = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
        a2_address = 2'd0; a2_dataW = 16'h0000; a2_ce = 1'b0; a2_we = 1'b0;
        a2_ld_start = 1'b0; a2_ld_valid = 1'b0; a2_ld_last = 1'b0; a2_ld_byte = 8'h00;
        step();
        step();

        // reset state
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_load_cnt", 32'(load_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_hold1", 32'(cpu_rst), 32'd1);
        step();
        chk("rel_idle", 32'(cpu_rst), 32'd0);

        // 1: even load 12 34 AB CD
        start_load();
        chk("t1_cpu_rst_up", 32'(cpu_rst), 32'd1);
        chk("t1_ready", 32'(ld_ready), 32'd1);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b1);
        chk("t1_load_cnt", 32'(load_cnt), 32'd2);
        chk("t1_ready_off", 32'(ld_ready), 32'd0);
        chk("t1_cpu_rst_c0", 32'(cpu_rst), 32'd1);
        step();
        chk("t1_cpu_rst_c1", 32'(cpu_rst), 32'd1);
        step();
        chk("t1_cpu_rst_c2", 32'(cpu_rst), 32'd0);
        rd(8'h00, 16'h1234, "t1_mem0");
        rd(8'h01, 16'hABCD, "t1_mem1");

        // 2: odd load 56 78 9A
        start_load();
        send(8'h56, 1'b0);
        send(8'h78, 1'b0);
        send(8'h9A, 1'b1);
        chk("t2_load_cnt", 32'(load_cnt), 32'd2);
        chk("t2_overflow", 32'(overflow), 32'd0);
        step();
        step();
        chk("t2_idle", 32'(cpu_rst), 32'd0);
        rd(8'h00, 16'h5678, "t2_mem0");
        rd(8'h01, 16'h9A00, "t2_mem1");

        // 3: CPU write in IDLE lands; the same write during a load is ignored
        address = 8'h05; dataW = 16'hBEEF; ce = 1'b1; we = 1'b1;
        step();
        ce = 1'b0; we = 1'b0;
        rd(8'h05, 16'hBEEF, "t3_cpu_wr");
        start_load();
        address = 8'h05; dataW = 16'hDEAD; ce = 1'b1; we = 1'b1;
        step();
        ce = 1'b0; we = 1'b0;
        rd(8'h05, 16'hBEEF, "t3_wr_blocked");

        // 5: gapped valid in the same load, plus ld_start while in LOAD_LO
        step();
        chk("t5_ready_gap0", 32'(ld_ready), 32'd1);
        chk("t5_cnt_gap0", 32'(load_cnt), 32'd0);
        send(8'h11, 1'b0);
        step();
        chk("t5_ready_gap1", 32'(ld_ready), 32'd1);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("t5_start_ignored_cnt", 32'(load_cnt), 32'd0);
        chk("t5_start_ignored_rst", 32'(cpu_rst), 32'd1);
        send(8'h22, 1'b0);
        chk("t5_cnt1", 32'(load_cnt), 32'd1);
        send(8'h33, 1'b0);
        step();
        step();
        chk("t5_ready_gap2", 32'(ld_ready), 32'd1);
        chk("t5_cnt_hold", 32'(load_cnt), 32'd1);
        send(8'h44, 1'b1);
        chk("t5_cnt2", 32'(load_cnt), 32'd2);
        step();
        step();
        chk("t5_idle", 32'(cpu_rst), 32'd0);
        rd(8'h00, 16'h1122, "t5_mem0");
        rd(8'h01, 16'h3344, "t5_mem1");

        // 4: AW=2 instance, 5 words into a 4-word RAM
        a2_ld_start = 1'b1;
        step();
        a2_ld_start = 1'b0;
        send2(8'h11, 1'b0); send2(8'h11, 1'b0);
        send2(8'h22, 1'b0); send2(8'h22, 1'b0);
        send2(8'h33, 1'b0); send2(8'h33, 1'b0);
        send2(8'h44, 1'b0); send2(8'h44, 1'b0);
        chk("t4_cnt_full", 32'(a2_load_cnt), 32'd4);
        chk("t4_ovf_not_yet", 32'(a2_overflow), 32'd0);
        send2(8'h55, 1'b0); send2(8'h55, 1'b1);
        chk("t4_cnt_sat", 32'(a2_load_cnt), 32'd4);
        chk("t4_overflow", 32'(a2_overflow), 32'd1);
        step();
        step();
        chk("t4_idle", 32'(a2_cpu_rst), 32'd0);
        rd2(2'd0, 16'h1111, "t4_mem0");
        rd2(2'd1, 16'h2222, "t4_mem1");
        rd2(2'd2, 16'h3333, "t4_mem2");
        rd2(2'd3, 16'h4444, "t4_mem3");

        // 6: reset after word 0 and the hi byte of word 1
        start_load();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        chk("t6_cnt_pre", 32'(load_cnt), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t6_load_cnt", 32'(load_cnt), 32'd0);
        chk("t6_ready", 32'(ld_ready), 32'd0);
        step();
        chk("t6_hold1", 32'(cpu_rst), 32'd1);
        step();
        chk("t6_idle", 32'(cpu_rst), 32'd0);
        rd(8'h00, 16'hAABB, "t6_mem0_kept");
        rd(8'h01, 16'h3344, "t6_mem1_untouched");
        rd(8'h05, 16'hBEEF, "t6_mem5_kept");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
